// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and decode-side resolution signals of the branch
// predictor/BTB, bundled so the pipeline and the predictor share one port.
// slave  : the predictor (consumes PC/update, produces prediction/redirect).
// master : the pipeline side that drives PC_IF and the resolved branch.
// Handshake: UPDATE_VALID qualifies all UPDATE_* fields; an update is taken by
// the predictor on the first rising clk edge where UPDATE_VALID=1 and STALL=0
// (STALL acts as not-ready). Holding UPDATE_VALID through a stall still yields
// exactly one commit. The lookup path has no handshake: it is combinational.
interface branch_predictor_btb_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] PC_IF;
  logic             PRED_HIT;
  logic             PRED_TAKEN;
  logic [WIDTH-1:0] PRED_NEXT_PC;
  logic             STALL;
  logic             UPDATE_VALID;
  logic [WIDTH-1:0] UPDATE_PC;
  logic             UPDATE_TAKEN;
  logic [WIDTH-1:0] UPDATE_TARGET;
  logic             UPDATE_PRED_TAKEN;
  logic [WIDTH-1:0] UPDATE_PRED_TARGET;
  logic             MISPREDICT;
  logic [WIDTH-1:0] RECOVERY_PC;
  logic [31:0]      STAT_BRANCHES;
  logic [31:0]      STAT_MISPREDICTS;

  modport slave (
    input  PC_IF, STALL, UPDATE_VALID, UPDATE_PC, UPDATE_TAKEN,
           UPDATE_TARGET, UPDATE_PRED_TAKEN, UPDATE_PRED_TARGET,
    output PRED_HIT, PRED_TAKEN, PRED_NEXT_PC, MISPREDICT, RECOVERY_PC,
           STAT_BRANCHES, STAT_MISPREDICTS
  );

  modport master (
    output PC_IF, STALL, UPDATE_VALID, UPDATE_PC, UPDATE_TAKEN,
           UPDATE_TARGET, UPDATE_PRED_TAKEN, UPDATE_PRED_TARGET,
    input  PRED_HIT, PRED_TAKEN, PRED_NEXT_PC, MISPREDICT, RECOVERY_PC,
           STAT_BRANCHES, STAT_MISPREDICTS
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating counters.
// IF-stage lookup is combinational on PC_IF; ID-stage resolution updates the
// table on the clock edge and raises MISPREDICT/RECOVERY_PC combinationally.
// Optional macro BP_STATS_EN adds saturating branch/mispredict counters; when
// undefined the STAT_* outputs are tied to zero.
module branch_predictor_btb #(
  parameter int WIDTH     = 32,
  parameter int ENTRIES   = 64,
  parameter int TAG_WIDTH = 10,
  parameter int CNT_BITS  = 2
) (
  input logic                    clk,
  input logic                    rst,
  branch_predictor_btb_if.slave  bp
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_LO   = IDX_BITS + 2;
  localparam int TAG_HI   = IDX_BITS + 1 + TAG_WIDTH;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(2 ** (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'(2 ** (CNT_BITS - 1) - 1);

  // Table storage
  logic                 valid_q  [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0]     target_q [ENTRIES];
  logic [CNT_BITS-1:0]  cnt_q    [ENTRIES];

  // Lookup side
  logic [IDX_BITS-1:0]  lk_idx;
  logic [TAG_WIDTH-1:0] lk_tag;
  logic                 lk_hit;
  logic                 lk_taken;

  // Update side
  logic [IDX_BITS-1:0]  up_idx;
  logic [TAG_WIDTH-1:0] up_tag;
  logic                 up_hit;
  logic                 commit;
  logic [CNT_BITS-1:0]  cnt_inc;
  logic [CNT_BITS-1:0]  cnt_dec;
  logic                 mispredict;

  // PC bits outside idx/tag (byte offset, high bits) are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.PC_IF, bp.UPDATE_PC};

  assign lk_idx = bp.PC_IF[IDX_BITS+1:2];
  assign lk_tag = bp.PC_IF[TAG_HI:TAG_LO];
  assign up_idx = bp.UPDATE_PC[IDX_BITS+1:2];
  assign up_tag = bp.UPDATE_PC[TAG_HI:TAG_LO];

  // Fetch-stage prediction from pre-update table contents
  always_comb begin
    lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken        = lk_hit && cnt_q[lk_idx][CNT_BITS-1];
    bp.PRED_HIT     = lk_hit;
    bp.PRED_TAKEN   = lk_taken;
    bp.PRED_NEXT_PC = lk_taken ? target_q[lk_idx] : bp.PC_IF + WIDTH'(4);
  end

  // Resolution: hit detection, counter steps and redirect
  always_comb begin
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    commit  = bp.UPDATE_VALID && !bp.STALL;
    cnt_inc = (cnt_q[up_idx] == CNT_MAX) ? cnt_q[up_idx] : cnt_q[up_idx] + CNT_BITS'(1);
    cnt_dec = (cnt_q[up_idx] == '0) ? cnt_q[up_idx] : cnt_q[up_idx] - CNT_BITS'(1);
    mispredict = bp.UPDATE_VALID &&
                 ((bp.UPDATE_TAKEN != bp.UPDATE_PRED_TAKEN) ||
                  (bp.UPDATE_TAKEN && (bp.UPDATE_TARGET != bp.UPDATE_PRED_TARGET)));
    bp.MISPREDICT  = mispredict;
    bp.RECOVERY_PC = bp.UPDATE_TAKEN ? bp.UPDATE_TARGET : bp.UPDATE_PC + WIDTH'(4);
  end

  // Table write: train on hit, allocate only on a taken miss; reset wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (commit) begin
      if (up_hit) begin
        if (bp.UPDATE_TAKEN) begin
          cnt_q[up_idx]    <= cnt_inc;
          target_q[up_idx] <= bp.UPDATE_TARGET;
        end else begin
          cnt_q[up_idx]    <= cnt_dec;
        end
      end else if (bp.UPDATE_TAKEN) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bp.UPDATE_TARGET;
        cnt_q[up_idx]    <= CNT_WT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  // Saturating event counters, one step per committed update
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (commit) begin
      if (stat_br_q != 32'hFFFF_FFFF) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict && (stat_mp_q != 32'hFFFF_FFFF)) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign bp.STAT_BRANCHES    = stat_br_q;
  assign bp.STAT_MISPREDICTS = stat_mp_q;
`else
  assign bp.STAT_BRANCHES    = 32'd0;
  assign bp.STAT_MISPREDICTS = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (ENTRIES=64, CNT_BITS=2, TAG_WIDTH=10).
module tb_branch_predictor_btb;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_br;
  logic [31:0] exp_mp;

  branch_predictor_btb_if #(.WIDTH(32)) bp ();

  branch_predictor_btb #(
    .WIDTH(32), .ENTRIES(64), .TAG_WIDTH(10), .CNT_BITS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Bench-side redirect rule, used only to count expected mispredicts.
  function automatic logic exp_misp();
    return bp.UPDATE_VALID &&
           ((bp.UPDATE_TAKEN != bp.UPDATE_PRED_TAKEN) ||
            (bp.UPDATE_TAKEN && (bp.UPDATE_TARGET != bp.UPDATE_PRED_TARGET)));
  endfunction

  // Advance one cycle; track expected stats for the edge about to happen.
  task automatic tick();
    if (rst) begin
      exp_br = 0;
      exp_mp = 0;
    end else if (bp.UPDATE_VALID && !bp.STALL) begin
      exp_br = exp_br + 1;
      if (exp_misp()) exp_mp = exp_mp + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bp.UPDATE_VALID       = v;
    bp.UPDATE_PC          = pc;
    bp.UPDATE_TAKEN       = tk;
    bp.UPDATE_TARGET      = tgt;
    bp.UPDATE_PRED_TAKEN  = ptk;
    bp.UPDATE_PRED_TARGET = ptgt;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] nxt);
    bp.PC_IF = pc;
    #1;
    check_eq({tag, "_hit"},   32'(bp.PRED_HIT),   32'(hit));
    check_eq({tag, "_taken"}, 32'(bp.PRED_TAKEN), 32'(tk));
    check_eq({tag, "_next"},  bp.PRED_NEXT_PC,    nxt);
  endtask

  task automatic check_stats(input string tag);
`ifdef BP_STATS_EN
    check_eq({tag, "_br"}, bp.STAT_BRANCHES,    exp_br);
    check_eq({tag, "_mp"}, bp.STAT_MISPREDICTS, exp_mp);
`else
    check_eq({tag, "_br"}, bp.STAT_BRANCHES,    32'd0);
    check_eq({tag, "_mp"}, bp.STAT_MISPREDICTS, 32'd0);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_br   = 0;
    exp_mp   = 0;
    rst      = 1'b1;
    bp.PC_IF = 32'h100;
    bp.STALL = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // reset state
    look("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    check_eq("rst_misp", 32'(bp.MISPREDICT), 32'd0);
    check_stats("rst_stats");

    // allocate 0x100 -> 0x80; same-cycle lookup still sees the empty entry
    set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    check_eq("alloc_misp", 32'(bp.MISPREDICT), 32'd1);
    check_eq("alloc_rec",  bp.RECOVERY_PC,     32'h80);
    look("alloc_same", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("alloc_after", 32'h100, 1'b1, 1'b1, 32'h80);

    // three correct taken updates: cnt 3,3,3
    set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    #1;
    check_eq("tk_ok_misp", 32'(bp.MISPREDICT), 32'd0);
    tick(); tick(); tick();
    // first not-taken: cnt 2, still predicts taken
    set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    check_eq("nt_misp", 32'(bp.MISPREDICT), 32'd1);
    check_eq("nt_rec",  bp.RECOVERY_PC,     32'h104);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("sat_c2", 32'h100, 1'b1, 1'b1, 32'h80);
    // second not-taken: cnt 1, predicts not taken
    set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("sat_c1", 32'h100, 1'b1, 1'b0, 32'h104);

    // taken with new target while predicted target differs: cnt 2, target 0x90
    set_upd(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    #1;
    check_eq("tgt_misp", 32'(bp.MISPREDICT), 32'd1);
    check_eq("tgt_rec",  bp.RECOVERY_PC,     32'h90);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("tgt_new", 32'h100, 1'b1, 1'b1, 32'h90);

    // stall: not-taken held 4 cycles, stalled for 3 -> exactly one step (cnt 1)
    set_upd(1'b1, 32'h100, 1'b0, 32'h90, 1'b1, 32'h90);
    bp.STALL = 1'b1;
    #1;
    check_eq("stall_misp", 32'(bp.MISPREDICT), 32'd1);
    tick();
    look("stall_hold", 32'h100, 1'b1, 1'b1, 32'h90);
    tick(); tick();
    bp.STALL = 1'b0;
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("stall_one", 32'h100, 1'b1, 1'b0, 32'h104);
    // one taken step back to 2 proves only one decrement happened
    set_upd(1'b1, 32'h100, 1'b1, 32'h90, 1'b0, 32'h0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("stall_back", 32'h100, 1'b1, 1'b1, 32'h90);
    check_stats("mid_stats");

    // aliasing: 0x200 maps to the same index and evicts 0x100
    set_upd(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);

    // not-taken on unallocated PCs leaves the table unchanged
    set_upd(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    set_upd(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("nt_miss_keep", 32'h200, 1'b1, 1'b1, 32'h300);
    look("nt_miss_400",  32'h400, 1'b0, 1'b0, 32'h404);
    look("nt_miss_44",   32'h44,  1'b0, 1'b0, 32'h48);

    // same-cycle collision on 0x200: old prediction now, new one after the edge
    set_upd(1'b1, 32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
    look("coll_old", 32'h200, 1'b1, 1'b1, 32'h300);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("coll_new", 32'h200, 1'b1, 1'b0, 32'h204);
    check_stats("pre_rst_stats");

    // reset during an update: table cleared, update lost
    set_upd(1'b1, 32'h200, 1'b1, 32'h500, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("rst_upd", 32'h200, 1'b0, 1'b0, 32'h204);
    check_stats("rst_upd_stats");

    // wraparound of PC+4 on both paths
    look("wrap_lk", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    set_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_eq("wrap_rec",  bp.RECOVERY_PC,     32'h0);
    check_eq("wrap_misp", 32'(bp.MISPREDICT), 32'd0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_stats("end_stats");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
